// File: rtl/execute_multicycle.sv
// execute_multicycle
//   Execute stage with a single-cycle ADD and iterative multi-cycle MUL (low
//   half), DIVU and REMU. It holds the flags register and back-pressures
//   upstream while an op iterates.
//
// Handshake: an op is taken on a rising edge when v_i & ~stall_o & ~flush_i.
//   stall_o = (state != IDLE) | (stall_i & v_o), combinational. Downstream
//   consumes the output on any edge where v_o & ~stall_i. While v_o & stall_i,
//   the whole output register (v_o, result_o, wb_r_o, wb_o, flags_o) holds.
//
// Optional feature macro: EXEC_MC_EARLY_OUT_EN. When defined, MUL with a zero
//   operand and DIVU/REMU with opr0 < opr1 skip RUN and finish through DONE.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   v_i, stall_o       input valid, upstream hold
//   op_i               00 ADD, 01 MUL, 10 DIVU, 11 REMU
//   opr0_i, opr1_i     operand A (dividend/multiplicand), operand B
//   wb_r_i, wb_en_i    destination index, write-back enable
//   flush_i            synchronous kill of in-flight op and output valid
//   stall_i            downstream hold
//   v_o, result_o      output valid, registered result
//   wb_r_o, wb_o       registered destination index, v_o & registered wb_en
//   flags_o            {V, S, Z, C}
//   dbg_state          current FSM state (0 IDLE, 1 RUN, 2 DONE)
module execute_multicycle #(
    parameter int W_OPR   = 32,
    parameter int W_RD    = 5,
    parameter int W_FLAGS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               v_i,
    output logic               stall_o,
    input  logic [1:0]         op_i,
    input  logic [W_OPR-1:0]   opr0_i,
    input  logic [W_OPR-1:0]   opr1_i,
    input  logic [W_RD-1:0]    wb_r_i,
    input  logic               wb_en_i,
    input  logic               flush_i,
    input  logic               stall_i,
    output logic               v_o,
    output logic [W_OPR-1:0]   result_o,
    output logic [W_RD-1:0]    wb_r_o,
    output logic               wb_o,
    output logic [W_FLAGS-1:0] flags_o,
    output logic [1:0]         dbg_state
);

    localparam int W_CNT = $clog2(W_OPR + 1);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [W_CNT-1:0] cnt;
    logic [1:0]       op_q;
    logic [W_OPR-1:0] opnd_q;   // multiplicand for MUL, divisor for DIVU/REMU
    logic [W_OPR-1:0] r_hi;     // product upper half / partial remainder
    logic [W_OPR-1:0] r_lo;     // multiplier and product lower half / quotient
    logic [W_RD-1:0]  wb_r_q;
    logic             wb_en_q;
    logic             div0_q;
    logic             wb_en_out;

    logic accept, out_free, is_add, div0_in, early_in;
    logic add_write, done_write;

    assign stall_o   = (state != IDLE) | (stall_i & v_o);
    assign out_free  = ~stall_i | ~v_o;
    assign accept    = v_i & ~stall_o & ~flush_i;
    assign is_add    = (op_i == OP_ADD);
    assign div0_in   = op_i[1] & (opr1_i == '0);
    assign add_write = accept & is_add;
    assign done_write = (state == DONE) & out_free & ~flush_i;
    assign wb_o      = v_o & wb_en_out;
    assign dbg_state = state;

`ifdef EXEC_MC_EARLY_OUT_EN
    assign early_in = ((op_i == OP_MUL) & ((opr0_i == '0) | (opr1_i == '0)))
                    | (op_i[1] & (opr0_i < opr1_i));
`else
    assign early_in = 1'b0;
`endif

    // ADD result and flags
    logic [W_OPR:0]     add_sum;
    logic [W_FLAGS-1:0] add_flags;
    always_comb begin
        add_sum      = {1'b0, opr0_i} + {1'b0, opr1_i};
        add_flags    = '0;
        add_flags[0] = add_sum[W_OPR];
        add_flags[1] = (add_sum[W_OPR-1:0] == '0);
        add_flags[2] = add_sum[W_OPR-1];
        add_flags[3] = (opr0_i[W_OPR-1] == opr1_i[W_OPR-1])
                     & (add_sum[W_OPR-1] != opr0_i[W_OPR-1]);
    end

    // Multi-cycle result and flags, read out of the iteration registers in DONE
    logic [W_OPR-1:0]   mc_res;
    logic [W_FLAGS-1:0] mc_flags;
    always_comb begin
        mc_res      = (op_q == OP_REMU) ? r_hi : r_lo;
        mc_flags    = '0;
        mc_flags[1] = (mc_res == '0);
        mc_flags[2] = mc_res[W_OPR-1];
        if (op_q == OP_MUL) begin
            mc_flags[0] = (r_hi != '0);
            mc_flags[3] = (r_hi != '0);
        end else begin
            mc_flags[0] = 1'b0;
            mc_flags[3] = div0_q;
        end
    end

    // One radix-2 step. MUL: shift-add into {r_hi, r_lo}, multiplier bits
    // leave r_lo from the bottom as product bits enter from the top.
    // DIV: restoring; the dividend bits leave r_lo from the top into the
    // remainder while quotient bits enter r_lo from the bottom.
    logic [W_OPR:0]   mul_sum;
    logic [W_OPR:0]   div_shift;
    logic [W_OPR+1:0] div_diff;
    always_comb begin
        mul_sum   = {1'b0, r_hi} + {1'b0, opnd_q};
        div_shift = {r_hi, r_lo[W_OPR-1]};
        div_diff  = {1'b0, div_shift} - {2'b0, opnd_q};
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !is_add) state_nxt = (div0_in || early_in) ? DONE : RUN;
            RUN:  if (cnt == W_CNT'(1)) state_nxt = DONE;
            DONE: if (out_free) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Iteration datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            wb_r_q  <= '0;
            wb_en_q <= 1'b0;
            div0_q  <= 1'b0;
        end else if (accept && !is_add) begin
            cnt     <= W_CNT'(W_OPR);
            op_q    <= op_i;
            wb_r_q  <= wb_r_i;
            wb_en_q <= wb_en_i;
            div0_q  <= div0_in;
            opnd_q  <= (op_i == OP_MUL) ? opr0_i : opr1_i;
            if (div0_in) begin
                r_hi <= opr0_i;
                r_lo <= '1;
            end else if (early_in) begin
                // MUL by zero -> 0; DIV with opr0 < opr1 -> q 0, r opr0
                r_hi <= (op_i == OP_MUL) ? '0 : opr0_i;
                r_lo <= '0;
            end else begin
                r_hi <= '0;
                r_lo <= (op_i == OP_MUL) ? opr1_i : opr0_i;
            end
        end else if (state == RUN) begin
            cnt <= cnt - W_CNT'(1);
            if (op_q == OP_MUL) begin
                if (r_lo[0]) begin
                    r_hi <= mul_sum[W_OPR:1];
                    r_lo <= {mul_sum[0], r_lo[W_OPR-1:1]};
                end else begin
                    r_hi <= {1'b0, r_hi[W_OPR-1:1]};
                    r_lo <= {r_hi[0], r_lo[W_OPR-1:1]};
                end
            end else begin
                if (!div_diff[W_OPR+1]) begin
                    r_hi <= div_diff[W_OPR-1:0];
                    r_lo <= {r_lo[W_OPR-2:0], 1'b1};
                end else begin
                    r_hi <= div_shift[W_OPR-1:0];
                    r_lo <= {r_lo[W_OPR-2:0], 1'b0};
                end
            end
        end
    end

    // Output register; flush wins, flags only change with a written result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_o       <= 1'b0;
            result_o  <= '0;
            wb_r_o    <= '0;
            wb_en_out <= 1'b0;
            flags_o   <= '0;
        end else if (flush_i) begin
            v_o <= 1'b0;
        end else if (add_write) begin
            v_o       <= 1'b1;
            result_o  <= add_sum[W_OPR-1:0];
            wb_r_o    <= wb_r_i;
            wb_en_out <= wb_en_i;
            flags_o   <= add_flags;
        end else if (done_write) begin
            v_o       <= 1'b1;
            result_o  <= mc_res;
            wb_r_o    <= wb_r_q;
            wb_en_out <= wb_en_q;
            flags_o   <= mc_flags;
        end else if (out_free) begin
            v_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_multicycle.sv
// Directed bench for execute_multicycle (W_OPR = 32).
module tb_execute_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_i;
    logic        stall_o;
    logic [1:0]  op_i;
    logic [31:0] opr0_i;
    logic [31:0] opr1_i;
    logic [4:0]  wb_r_i;
    logic        wb_en_i;
    logic        flush_i;
    logic        stall_i;
    logic        v_o;
    logic [31:0] result_o;
    logic [4:0]  wb_r_o;
    logic        wb_o;
    logic [3:0]  flags_o;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int lat, stalls;

`ifdef EXEC_MC_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    execute_multicycle #(.W_OPR(32), .W_RD(5), .W_FLAGS(4)) dut (
        .clk(clk), .reset(reset), .v_i(v_i), .stall_o(stall_o), .op_i(op_i),
        .opr0_i(opr0_i), .opr1_i(opr1_i), .wb_r_i(wb_r_i), .wb_en_i(wb_en_i),
        .flush_i(flush_i), .stall_i(stall_i), .v_o(v_o), .result_o(result_o),
        .wb_r_o(wb_r_o), .wb_o(wb_o), .flags_o(flags_o), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: present one op for one edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wbr, input logic wben);
        v_i = 1'b1; op_i = op; opr0_i = a; opr1_i = b; wb_r_i = wbr; wb_en_i = wben;
        tick();
        v_i = 1'b0;
    endtask

    // edges after the accept edge until v_o, and cycles with stall_o high
    task automatic wait_done(output int l, output int s);
        l = 0; s = 0;
        while (!v_o && l < 100) begin
            if (stall_o) s++;
            tick();
            l++;
        end
    endtask

    initial begin
        reset = 1'b1; v_i = 0; op_i = 0; opr0_i = 0; opr1_i = 0; wb_r_i = 0;
        wb_en_i = 0; flush_i = 0; stall_i = 0;
        tick(); tick();
        chk("rst_v_o", v_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_wb_r", wb_r_o, 0);
        chk("rst_wb_o", wb_o, 0);
        chk("rst_flags", flags_o, 0);
        chk("rst_stall_o", stall_o, 0);
        chk("rst_state", dbg_state, 0);
        reset = 1'b0;
        tick();

        // ADD 7 + 0xFFFFFFF9 = 0 with carry
        v_i = 1; op_i = 2'b00; opr0_i = 32'd7; opr1_i = 32'hFFFF_FFF9; wb_r_i = 5'd3; wb_en_i = 1;
        #1;
        chk("add_stall_pre", stall_o, 0);
        tick();
        v_i = 0;
        chk("add_v_o", v_o, 1);
        chk("add_result", result_o, 0);
        chk("add_flags", flags_o, 4'b0011);
        chk("add_wb_o", wb_o, 1);
        chk("add_wb_r", wb_r_o, 3);
        chk("add_stall_post", stall_o, 0);
        tick();
        chk("add_v_o_drop", v_o, 0);

        // MUL 12345 * 6789
        issue(2'b01, 32'd12345, 32'd6789, 5'd5, 1'b1);
        wait_done(lat, stalls);
        chk("mul_latency", lat, 33);
        chk("mul_stall_cycles", stalls, 33);
        chk("mul_result", result_o, 32'd83810205);
        chk("mul_flags", flags_o, 4'b0000);
        chk("mul_wb_r", wb_r_o, 5);
        chk("mul_wb_o", wb_o, 1);

        // downstream stall holds output and blocks a new op
        stall_i = 1;
        v_i = 1; op_i = 2'b00; opr0_i = 32'd9; opr1_i = 32'd9;
        #1;
        chk("hold_stall_o", stall_o, 1);
        tick(); tick(); tick();
        chk("hold_v_o", v_o, 1);
        chk("hold_result", result_o, 32'd83810205);
        v_i = 0; stall_i = 0;
        tick();
        chk("hold_release_v_o", v_o, 0);
        chk("hold_not_accepted", result_o, 32'd83810205);

        // DIVU / REMU
        issue(2'b10, 32'd100, 32'd7, 5'd1, 1'b1);
        wait_done(lat, stalls);
        chk("divu_latency", lat, 33);
        chk("divu_result", result_o, 32'd14);
        chk("divu_flags", flags_o, 4'b0000);
        issue(2'b11, 32'd100, 32'd7, 5'd2, 1'b1);
        wait_done(lat, stalls);
        chk("remu_result", result_o, 32'd2);
        chk("remu_flags", flags_o, 4'b0000);

        // divide by zero
        issue(2'b10, 32'd5, 32'd0, 5'd4, 1'b1);
        wait_done(lat, stalls);
        chk("div0_latency", lat, 1);
        chk("div0_result", result_o, 32'hFFFF_FFFF);
        chk("div0_flags", flags_o, 4'b1100);
        issue(2'b11, 32'd7, 32'd0, 5'd4, 1'b1);
        wait_done(lat, stalls);
        chk("rem0_latency", lat, 1);
        chk("rem0_result", result_o, 32'd7);
        chk("rem0_flags", flags_o, 4'b1000);

        // MUL with nonzero upper half, no write-back
        issue(2'b01, 32'h0001_0000, 32'h0001_0000, 5'd6, 1'b0);
        wait_done(lat, stalls);
        chk("mulhi_result", result_o, 32'd0);
        chk("mulhi_flags", flags_o, 4'b1011);
        chk("mulhi_wb_o", wb_o, 0);

        // ADD signed overflow
        issue(2'b00, 32'h7FFF_FFFF, 32'd1, 5'd7, 1'b1);
        chk("addov_result", result_o, 32'h8000_0000);
        chk("addov_flags", flags_o, 4'b1100);

        // flush in RUN cycle 10 of a DIVU
        issue(2'b10, 32'd1000, 32'd3, 5'd8, 1'b1);
        repeat (10) tick();
        chk("flush_busy", stall_o, 1);
        flush_i = 1;
        tick();
        flush_i = 0;
        chk("flush_stall_o", stall_o, 0);
        chk("flush_v_o", v_o, 0);
        chk("flush_flags_kept", flags_o, 4'b1100);
        chk("flush_state", dbg_state, 0);
        issue(2'b00, 32'd1, 32'd1, 5'd9, 1'b1);
        chk("after_flush_v_o", v_o, 1);
        chk("after_flush_result", result_o, 32'd2);
        chk("after_flush_flags", flags_o, 4'b0000);

        // op presented with flush is not accepted; flush clears v_o
        v_i = 1; op_i = 2'b00; opr0_i = 32'd5; opr1_i = 32'd5; flush_i = 1;
        tick();
        v_i = 0; flush_i = 0;
        chk("flush_op_v_o", v_o, 0);
        chk("flush_op_result", result_o, 32'd2);
        tick();
        chk("flush_op_idle", v_o, 0);

        // early-out candidates
        issue(2'b10, 32'd3, 32'd9, 5'd10, 1'b1);
        wait_done(lat, stalls);
        chk("eo_divu_latency", lat, EO_LAT);
        chk("eo_divu_result", result_o, 32'd0);
        issue(2'b11, 32'd3, 32'd9, 5'd10, 1'b1);
        wait_done(lat, stalls);
        chk("eo_remu_latency", lat, EO_LAT);
        chk("eo_remu_result", result_o, 32'd3);
        issue(2'b01, 32'd0, 32'd5, 5'd11, 1'b1);
        wait_done(lat, stalls);
        chk("eo_mul_latency", lat, EO_LAT);
        chk("eo_mul_result", result_o, 32'd0);
        chk("eo_mul_flags", flags_o, 4'b0010);

        // reset in the middle of an op
        issue(2'b01, 32'd3, 32'd4, 5'd12, 1'b1);
        repeat (5) tick();
        reset = 1;
        #1;
        chk("midrst_stall_o", stall_o, 0);
        chk("midrst_v_o", v_o, 0);
        chk("midrst_state", dbg_state, 0);
        tick();
        reset = 0;
        tick();
        chk("midrst_no_output", v_o, 0);
        issue(2'b00, 32'd2, 32'd3, 5'd13, 1'b1);
        chk("midrst_add_result", result_o, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
